simon_seq_gen: RTL and testbench
================================

# simon_seq_gen

Pattern source for the lab3 Simon game. It holds the game seed and the current sequence length, and replays the pseudo-random LED sequence one symbol at a time to the game controller. It sits directly upstream of the controller's playback and compare logic. The same sequence is regenerated on every replay from a stored seed, so no per-step pattern memory is needed.

## Interface
- LFSR_W, 16, width of the entropy and replay LFSRs
- SEED, 16'hACE1, reset seed; also substituted for any zero seed
- LEN_W, 7, width of seq_len and pos; maximum length is 2^LEN_W-1 (127)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- new_game  in  1  one-cycle pulse; captures the entropy LFSR as seed, sets seq_len=1, starts replay
- seed_ld  in  1  one-cycle pulse; like new_game, but the seed is taken from seed_in
- seed_in  in  LFSR_W  explicit seed used by seed_ld
- extend  in  1  one-cycle pulse; seq_len+1, saturating
- restart  in  1  one-cycle pulse; rewind replay to pos 0
- next  in  1  consumer accepts the current symbol
- sym_valid  out  1  sym, sym_onehot and last are meaningful
- sym  out  4  LED index, 0..9
- sym_onehot  out  10  1<<sym; all zero when sym_valid=0
- last  out  1  current symbol is at pos == seq_len-1
- seq_len  out  LEN_W  current sequence length
- pos  out  LEN_W  index of the current symbol
- max_hit  out  1  seq_len == 2^LEN_W-1

## Operation
- Both LFSRs are 16-bit Galois, shift right, polynomial mask 16'hB400: if lsb=1, next = (x>>1)^16'hB400, else next = x>>1.
- Entropy LFSR: steps every cycle; never stops.
- Seed selection: new_game uses the entropy value; seed_ld uses seed_in. A zero value is replaced by SEED.
- Replay LFSR: loaded with the game seed on new_game, seed_ld or restart. Steps once per accepted symbol (next && sym_valid).
- Symbol mapping: sym = (replay[7:0] * 10)[11:8], an 8-bit × 4-bit product giving a 12-bit result, so 0..9 and no rejection is needed.
- States:
  - IDLE: after reset; sym_valid=0.
  - PLAY: sym_valid=1.
  - DONE: sym_valid=0.
- Transitions:
  - IDLE→PLAY on new_game or seed_ld.
  - PLAY→DONE on an accept while last=1.
  - PLAY/DONE→PLAY on restart, new_game or seed_ld.
  - restart in IDLE is ignored.
- Accept in PLAY with last=0: pos+1, replay steps.
- Accept on the last symbol: pos holds, state goes to DONE.
- extend: seq_len+1 unless max_hit; legal in any state except IDLE.
  - extend in DONE leaves DONE; the controller must restart.
  - extend in PLAY lengthens the running replay, so last is re-evaluated.
- Priority in one cycle: seed_ld > new_game > restart > next.
  - extend is additive with restart.
  - extend is ignored when combined with new_game or seed_ld; seq_len is forced to 1.
  - next in the same cycle as any load or restart is ignored.
  - next with sym_valid=0 is ignored.

## Timing
- Reset values: state IDLE, sym_valid=0, sym=0, sym_onehot=0, last=0, pos=0, seq_len=0, max_hit=0, entropy=SEED, game seed=SEED, replay=SEED.
- All state is registered. Outputs are decoded from registers only; there is no input→output combinational path.
- Load/restart asserted before edge k: after edge k, pos=0, sym_valid=1, and sym reflects the seed.
- Throughput: one symbol per cycle with next held high.
- seq_len=N: exactly N accepts from restart to DONE.
- Reset asserted mid-replay: immediate return to reset values; the seed is lost.

## Structure
- Package simon_pkg holds:
  - LFSR_MASK (16'hB400), DEFAULT_SEED, NUM_LEDS (10);
  - typedef enum seq_state_t {IDLE, PLAY, DONE};
  - function lfsr_next() and function sym_of() (multiply-shift mapping).
- Sub-module: simon_lfsr16, a load/step/hold register used for both LFSRs: entropy with step=1 and no load; replay with load=seed and step=accept.
- Top-level simon_seq_gen holds the FSM, the seq_len/pos counters and the seed register.

## Test plan
- Reset, then seed_ld with seed_in=16'hACE1 → sym_valid=1, sym=8, sym_onehot=10'b01_0000_0000, pos=0, seq_len=1, last=1.
- Same seed, extend once, restart, next held → sym sequence 8 then 4; after the 2nd accept sym_valid=0, pos=1.
- seed_ld with seed_in=0 → identical output to seed 16'hACE1.
- 126 extends → seq_len=127, max_hit=1. A 127th extend → seq_len stays 127. Full replay emits exactly 127 symbols, all ≤ 9.
- Same-cycle cases:
  - restart+extend with seq_len=3 → seq_len=4, pos=0.
  - next+restart → pos=0, replay not stepped.
  - new_game+extend → seq_len=1.
- Reset asserted at pos=5 mid-replay → all outputs at reset values asynchronously. restart afterwards is ignored until a new_game.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_pkg : shared constants, state type and LFSR/symbol helpers          |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
package simon_pkg;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          NUM_LEDS     = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
    endfunction

    // Multiply-shift maps the low byte uniformly enough onto 0..9 without rejection.
    function automatic logic [3:0] sym_of(input logic [15:0] x);
        logic [11:0] p;
        p = 12'(x[7:0]) * 12'(NUM_LEDS);
        return p[11:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_lfsr16 : 16-bit Galois LFSR with load (priority) and step enables   |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module simon_lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] INIT = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= INIT;
        end else if (load) begin
            r_q <= load_val;
        end else if (step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/simon_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_seq_gen : seeded pseudo-random LED sequence replay for Simon game   |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module simon_seq_gen
    import simon_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
    parameter int                LEN_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_game,
    input  logic                seed_ld,
    input  logic [LFSR_W-1:0]   seed_in,
    input  logic                extend,
    input  logic                restart,
    input  logic                next,
    output logic                sym_valid,
    output logic [3:0]          sym,
    output logic [NUM_LEDS-1:0] sym_onehot,
    output logic                last,
    output logic [LEN_W-1:0]    seq_len,
    output logic [LEN_W-1:0]    pos,
    output logic                max_hit
);

    localparam logic [LEN_W-1:0] c_LEN_MAX = '1;

    seq_state_t        r_state, w_state_nxt;
    logic [LFSR_W-1:0] r_seed;
    logic [LFSR_W-1:0] w_entropy, w_replay, w_cand, w_new_seed, w_replay_ld_val;
    logic [LEN_W-1:0]  r_len, r_pos;
    logic              w_load, w_restart, w_accept, w_replay_ld, w_last, w_max;

    simon_lfsr16 #(.INIT(SEED)) u_entropy (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ('0),
        .step     (1'b1),
        .q        (w_entropy)
    );

    simon_lfsr16 #(.INIT(SEED)) u_replay (
        .clk      (clk),
        .rst      (rst),
        .load     (w_replay_ld),
        .load_val (w_replay_ld_val),
        .step     (w_accept),
        .q        (w_replay)
    );

    // Loads outrank restart, which outranks accept; a zero seed would lock the LFSR.
    assign w_load          = seed_ld | new_game;
    assign w_cand          = seed_ld ? seed_in : w_entropy;
    assign w_new_seed      = (w_cand == '0) ? SEED : w_cand;
    assign w_restart       = restart & ~w_load & (r_state != IDLE);
    assign w_accept        = next & (r_state == PLAY) & ~w_load & ~restart;
    assign w_replay_ld     = w_load | w_restart;
    assign w_replay_ld_val = w_load ? w_new_seed : r_seed;
    assign w_max           = (r_len == c_LEN_MAX);
    assign w_last          = (r_state == PLAY) && (r_pos == (r_len - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seed <= SEED;
            r_len  <= '0;
            r_pos  <= '0;
        end else begin
            if (w_load) begin
                r_seed <= w_new_seed;
            end
            if (w_load) begin
                r_len <= LEN_W'(1);
            end else if (extend && (r_state != IDLE) && !w_max) begin
                r_len <= r_len + LEN_W'(1);
            end
            if (w_replay_ld) begin
                r_pos <= '0;
            end else if (w_accept && !w_last) begin
                r_pos <= r_pos + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load || w_restart) begin
            w_state_nxt = PLAY;
        end else if (w_accept && w_last) begin
            w_state_nxt = DONE;
        end
    end

    always_comb begin
        sym_valid  = (r_state == PLAY);
        sym        = '0;
        sym_onehot = '0;
        if (r_state == PLAY) begin
            sym        = sym_of(w_replay);
            sym_onehot = NUM_LEDS'(1) << sym;
        end
        last    = w_last;
        seq_len = r_len;
        pos     = r_pos;
        max_hit = w_max;
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_simon_seq_gen : scoreboard bench for simon_seq_gen                     |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_simon_seq_gen;

    logic        clk = 1'b0;
    logic        rst, new_game, seed_ld, extend, restart, next;
    logic [15:0] seed_in;
    logic        sym_valid, last, max_hit;
    logic [3:0]  sym;
    logic [9:0]  sym_onehot;
    logic [6:0]  seq_len, pos;

    typedef struct {
        int s;
        int p;
        int l;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    simon_seq_gen dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .seed_ld    (seed_ld),
        .seed_in    (seed_in),
        .extend     (extend),
        .restart    (restart),
        .next       (next),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .sym_onehot (sym_onehot),
        .last       (last),
        .seq_len    (seq_len),
        .pos        (pos),
        .max_hit    (max_hit)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] m_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int m_sym(input logic [15:0] x);
        return ((int'(x[7:0]) * 10) >> 8) & 15;
    endfunction

    task automatic push(input int s, input int p, input int l);
        exp_t e;
        e.s = s; e.p = p; e.l = l;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted symbol must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst && sym_valid && next && !restart && !new_game && !seed_ld) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_accept: sym %0d pos %0d, none expected", sym, pos);
            end else begin
                e = q.pop_front();
                check("acc_sym", int'(sym), e.s);
                check("acc_onehot", int'(sym_onehot), 1 << e.s);
                check("acc_pos", int'(pos), e.p);
                check("acc_last", int'(last), e.l);
                check("acc_range", int'(sym <= 4'd9), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] x;
        rst = 1'b0; new_game = 1'b0; seed_ld = 1'b0; seed_in = '0;
        extend = 1'b0; restart = 1'b0; next = 1'b0;
        cyc(); cyc();
        check("rst_valid", int'(sym_valid), 0);
        check("rst_sym", int'(sym), 0);
        check("rst_onehot", int'(sym_onehot), 0);
        check("rst_last", int'(last), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_len", int'(seq_len), 0);
        check("rst_max", int'(max_hit), 0);
        rst = 1'b1;
        cyc();

        // Explicit seed ACE1: low byte E1 -> 225*10=0x8CA -> 8
        seed_ld = 1'b1; seed_in = 16'hACE1;
        cyc();
        seed_ld = 1'b0;
        check("ld_valid", int'(sym_valid), 1);
        check("ld_sym", int'(sym), 8);
        check("ld_onehot", int'(sym_onehot), 'h100);
        check("ld_pos", int'(pos), 0);
        check("ld_len", int'(seq_len), 1);
        check("ld_last", int'(last), 1);

        extend = 1'b1; cyc(); extend = 1'b0;
        check("ext_len", int'(seq_len), 2);
        check("ext_last", int'(last), 0);
        restart = 1'b1; cyc(); restart = 1'b0;
        check("rs_pos", int'(pos), 0);
        push(8, 0, 0); push(4, 1, 1);
        next = 1'b1; cyc(); cyc(); next = 1'b0;
        check("done_valid", int'(sym_valid), 0);
        check("done_pos", int'(pos), 1);
        check("done_onehot", int'(sym_onehot), 0);

        // Zero seed falls back to ACE1
        seed_ld = 1'b1; seed_in = 16'h0000; cyc(); seed_ld = 1'b0;
        check("z_sym", int'(sym), 8);
        check("z_len", int'(seq_len), 1);
        check("z_last", int'(last), 1);
        push(8, 0, 1);
        next = 1'b1; cyc(); next = 1'b0;
        check("z_done", int'(sym_valid), 0);

        // Saturate length from DONE, then replay all 127 symbols
        extend = 1'b1; repeat (126) cyc(); extend = 1'b0;
        check("sat_len", int'(seq_len), 127);
        check("sat_max", int'(max_hit), 1);
        check("sat_stay_done", int'(sym_valid), 0);
        extend = 1'b1; cyc(); extend = 1'b0;
        check("sat_len2", int'(seq_len), 127);
        restart = 1'b1; cyc(); restart = 1'b0;
        check("full_sym0", int'(sym), 8);
        x = 16'hACE1;
        for (int i = 0; i < 127; i++) begin
            push(m_sym(x), i, (i == 126) ? 1 : 0);
            x = m_next(x);
        end
        next = 1'b1; repeat (127) cyc(); next = 1'b0;
        check("full_done", int'(sym_valid), 0);
        check("full_pos", int'(pos), 126);

        // new_game with extend: length forced to 1
        new_game = 1'b1; extend = 1'b1; cyc(); new_game = 1'b0; extend = 1'b0;
        check("ng_len", int'(seq_len), 1);
        check("ng_pos", int'(pos), 0);
        check("ng_valid", int'(sym_valid), 1);

        // Seed 1234: symbols 2,1,5,2,1,5 for pos 0..5
        seed_ld = 1'b1; seed_in = 16'h1234; cyc(); seed_ld = 1'b0;
        extend = 1'b1; cyc(); cyc(); extend = 1'b0;
        check("s_len3", int'(seq_len), 3);
        restart = 1'b1; extend = 1'b1; cyc(); restart = 1'b0; extend = 1'b0;
        check("rx_len", int'(seq_len), 4);
        check("rx_pos", int'(pos), 0);
        check("rx_sym", int'(sym), 2);
        push(2, 0, 0);
        next = 1'b1; cyc(); next = 1'b0;
        check("s_pos1", int'(pos), 1);
        next = 1'b1; restart = 1'b1; cyc(); next = 1'b0; restart = 1'b0;
        check("nr_pos", int'(pos), 0);
        check("nr_sym", int'(sym), 2);
        push(2, 0, 0); push(1, 1, 0);
        next = 1'b1; cyc(); cyc(); next = 1'b0;
        check("s_pos2", int'(pos), 2);
        check("s_sym2", int'(sym), 5);
        extend = 1'b1; cyc(); cyc(); extend = 1'b0;
        check("s_len6", int'(seq_len), 6);
        push(5, 2, 0); push(2, 3, 0); push(1, 4, 0);
        next = 1'b1; repeat (3) cyc(); next = 1'b0;
        check("s_pos5", int'(pos), 5);
        check("s_sym5", int'(sym), 5);
        check("s_last5", int'(last), 1);

        // Asynchronous reset mid-replay
        #2 rst = 1'b0;
        #1;
        check("ar_valid", int'(sym_valid), 0);
        check("ar_sym", int'(sym), 0);
        check("ar_onehot", int'(sym_onehot), 0);
        check("ar_pos", int'(pos), 0);
        check("ar_len", int'(seq_len), 0);
        check("ar_last", int'(last), 0);
        check("ar_max", int'(max_hit), 0);
        rst = 1'b1;
        restart = 1'b1; cyc(); restart = 1'b0;
        check("idle_rs_valid", int'(sym_valid), 0);
        check("idle_rs_len", int'(seq_len), 0);
        new_game = 1'b1; cyc(); new_game = 1'b0;
        check("ng2_valid", int'(sym_valid), 1);
        check("ng2_len", int'(seq_len), 1);

        cyc();
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
